// File: rtl/jzjpcc_exmem_resultstage.sv
// Execute->memory pipeline register for the ALU result path: captures result and control,
// qualifies write/load/store strobes, and provides the bypass value back to execute.
module jzjpcc_exmem_resultstage #(
  parameter int PC_MAX_B = 15
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic               stall_memory,
  input  logic               flush_memory,
  input  logic               valid_execute,
  input  logic [31:0]        aluResult_execute,
  input  logic [31:0]        rs2_execute,
  input  logic [31:0]        immediate_execute,
  input  logic [PC_MAX_B:2]  currentPC_execute,
  input  logic [4:0]         rdAddr_execute,
  input  logic               rdWrite_execute,
  input  logic [1:0]         wbSrc_execute,
  input  logic               memRead_execute,
  input  logic               memWrite_execute,
  input  logic [2:0]         funct3_execute,
  output logic               valid_memory,
  output logic [31:0]        aluResult_memory,
  output logic [31:0]        rs2_memory,
  output logic [31:0]        linkAddr_memory,
  output logic [31:0]        immediate_memory,
  output logic [4:0]         rdAddr_memory,
  output logic               rdWrite_memory,
  output logic [1:0]         wbSrc_memory,
  output logic               memRead_memory,
  output logic               memWrite_memory,
  output logic [2:0]         funct3_memory,
  output logic [31:0]        forwardValue_memory,
  output logic               forwardValid_memory,
  output logic               loadPending_memory
);

  logic              valid_r;
  logic [31:0]       alu_result_r;
  logic [31:0]       rs2_r;
  logic [31:0]       link_addr_r;
  logic [31:0]       immediate_r;
  logic [4:0]        rd_addr_r;
  logic              rd_write_r;
  logic [1:0]        wb_src_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [2:0]        funct3_r;

  logic [PC_MAX_B:0] link_sum_s;
  logic [31:0]       link_ext_s;
  logic              rd_write_qual_s;
  logic [31:0]       forward_value_s;

  // PC+4 at PC width so the last word wraps to zero, then zero-extend
  assign link_sum_s      = {currentPC_execute, 2'b00} + {{(PC_MAX_B-2){1'b0}}, 3'b100};
  assign rd_write_qual_s = valid_execute & rdWrite_execute & (rdAddr_execute != 5'd0);

  // zero-extension of the link address to a full register word
  always_comb begin
    link_ext_s = 32'h0000_0000;
    link_ext_s[PC_MAX_B:0] = link_sum_s;
  end

  // pipeline register: flush clears the strobes only, stall holds everything
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      valid_r      <= 1'b0;
      alu_result_r <= 32'h0000_0000;
      rs2_r        <= 32'h0000_0000;
      link_addr_r  <= 32'h0000_0000;
      immediate_r  <= 32'h0000_0000;
      rd_addr_r    <= 5'd0;
      rd_write_r   <= 1'b0;
      wb_src_r     <= 2'b00;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      funct3_r     <= 3'd0;
    end else if (flush_memory) begin
      valid_r      <= 1'b0;
      rd_write_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end else if (!stall_memory) begin
      valid_r      <= valid_execute;
      alu_result_r <= aluResult_execute;
      rs2_r        <= rs2_execute;
      link_addr_r  <= link_ext_s;
      immediate_r  <= immediate_execute;
      rd_addr_r    <= rdAddr_execute;
      rd_write_r   <= rd_write_qual_s;
      wb_src_r     <= wbSrc_execute;
      mem_read_r   <= valid_execute & memRead_execute;
      mem_write_r  <= valid_execute & memWrite_execute;
      funct3_r     <= funct3_execute;
    end
  end

  // bypass value selection; load data is not available yet, so ALU result stands in
  always_comb begin
    forward_value_s = alu_result_r;
    case (wb_src_r)
      2'b00:   forward_value_s = alu_result_r;
      2'b01:   forward_value_s = alu_result_r;
      2'b10:   forward_value_s = link_addr_r;
      2'b11:   forward_value_s = immediate_r;
      default: forward_value_s = alu_result_r;
    endcase
  end

  assign valid_memory        = valid_r;
  assign aluResult_memory    = alu_result_r;
  assign rs2_memory          = rs2_r;
  assign linkAddr_memory     = link_addr_r;
  assign immediate_memory    = immediate_r;
  assign rdAddr_memory       = rd_addr_r;
  assign rdWrite_memory      = rd_write_r;
  assign wbSrc_memory        = wb_src_r;
  assign memRead_memory      = mem_read_r;
  assign memWrite_memory     = mem_write_r;
  assign funct3_memory       = funct3_r;
  assign forwardValue_memory = forward_value_s;
  assign forwardValid_memory = rd_write_r & (wb_src_r != 2'b01);
  assign loadPending_memory  = valid_r & mem_read_r;

endmodule
